// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    // Bit counter width; kept at least one bit so WIDTH=1 still has a counter.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit combinational full adder; the only arithmetic in the serial adder.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands shift LSB-first through one full-adder cell,
// carry held in a flop, sum collected MSB-in into a shift register.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned    CntW    = cnt_width(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] areg_q, areg_d;
    logic [WIDTH-1:0] breg_q, breg_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             cell_s, cell_co;

    full_adder_cell u_cell (
        .a  (areg_q[0]),
        .b  (breg_q[0]),
        .ci (carry_q),
        .s  (cell_s),
        .co (cell_co)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        areg_d  = areg_q;
        breg_d  = breg_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    areg_d  = a;
                    breg_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                // New sum bit enters at the MSB so the first bit ends up in bit 0.
                sum_d   = (sum_q >> 1) | (WIDTH'(cell_s) << (WIDTH - 1));
                areg_d  = areg_q >> 1;
                breg_d  = breg_q >> 1;
                carry_d = cell_co;
                cnt_d   = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    cout_d  = cell_co;
                    cnt_d   = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            areg_q  <= '0;
            breg_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            areg_q  <= areg_d;
            breg_q  <= breg_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == StShift);
    assign done = (state_q == StDone);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
